// File: rtl/wavelet_delay_aligner.sv
// -----------------------------------------------------------------------------
// wavelet_delay_aligner
//
// Purpose:
//   Multi-channel delay aligner for wavelet subband streams. Each channel owns a
//   circular sample buffer and a runtime-programmable delay. A single shared
//   write pointer advances on every accepted input sample. Per-channel fill
//   counters track how many samples have been seen since the last reset or
//   reconfiguration, so the block can flag when each channel (and the whole
//   set) is producing meaningful, time-aligned data.
//
// Optional feature:
//   WAVELET_ALIGN_MISALIGN_CNT_EN - adds a 16-bit saturating counter of input
//   samples on which only part of the channel set is valid.
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   in_valid      in   sample enable, common to all channels
//   data_in       in   NUM_CH packed samples, channel 0 in the LSBs
//   cfg_wr        in   one-cycle strobe writing the delay of one channel
//   cfg_ch        in   target channel of cfg_wr (out-of-range is ignored)
//   cfg_delay     in   requested delay in samples (clamped to MAX_DELAY)
//   data_out      out  delayed samples, packed like data_in
//   ch_valid      out  per-channel output valid
//   aligned_valid out  pulse: every channel valid on this output sample
//   busy          out  at least one channel is still refilling
//   misalign_cnt  out  (optional) partial-valid sample counter
// -----------------------------------------------------------------------------
module wavelet_delay_aligner #(
    parameter int ADC_WIDTH = 14,
    parameter int NUM_CH    = 4,
    parameter int MAX_DELAY = 16,
    parameter int DLY_W     = $clog2(MAX_DELAY) + 1
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          in_valid,
    input  logic [NUM_CH*ADC_WIDTH-1:0]                   data_in,
    input  logic                                          cfg_wr,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [DLY_W-1:0]                              cfg_delay,
    output logic [NUM_CH*ADC_WIDTH-1:0]                   data_out,
    output logic [NUM_CH-1:0]                             ch_valid,
    output logic                                          aligned_valid,
    output logic                                          busy
`ifdef WAVELET_ALIGN_MISALIGN_CNT_EN
    ,
    output logic [15:0]                                   misalign_cnt
`endif
);

    localparam int PTR_W = $clog2(MAX_DELAY);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BUS_W = NUM_CH * ADC_WIDTH;

    localparam logic [DLY_W-1:0] MAX_DLY_L  = DLY_W'(MAX_DELAY);
    localparam logic [CH_W:0]    NUM_CH_L   = (CH_W + 1)'(NUM_CH);
    localparam logic [DLY_W-1:0] DLY_ZERO_L = {DLY_W{1'b0}};
    localparam logic [DLY_W-1:0] DLY_ONE_L  = DLY_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE_L  = PTR_W'(1);

    // Requested delays beyond the buffer depth saturate to the deepest tap.
    function automatic logic [DLY_W-1:0] clamp_delay(input logic [DLY_W-1:0] d);
        logic [DLY_W-1:0] r;
        if (d > MAX_DLY_L) begin
            r = MAX_DLY_L;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Read tap. A delay of MAX_DELAY has zero low bits and therefore lands on
    // the write slot itself, returning the entry about to be overwritten.
    function automatic logic [PTR_W-1:0] tap_addr(input logic [PTR_W-1:0] ptr,
                                                  input logic [DLY_W-1:0] d);
        return ptr - d[PTR_W-1:0];
    endfunction

    // ---------------------------------------------------------------- state
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [ADC_WIDTH-1:0] r_mem      [NUM_CH][MAX_DELAY];
    logic [DLY_W-1:0]     r_delay    [NUM_CH];
    logic [DLY_W-1:0]     r_fill     [NUM_CH];
    logic [NUM_CH-1:0]    r_ch_valid;
    logic [BUS_W-1:0]     r_data_out;
    logic                 r_aligned;
    logic                 r_busy;

    // ---------------------------------------------------------------- comb
    logic                 w_cfg_ok;
    logic [DLY_W-1:0]     w_cfg_dly;
    logic [NUM_CH-1:0]    w_cfg_hit;
    logic [NUM_CH-1:0]    w_fill_ok;
    logic [NUM_CH-1:0]    w_fill_short;
    logic [NUM_CH-1:0]    w_ch_valid_nxt;
    logic [BUS_W-1:0]     w_rd_data;

    // Configuration decode and next per-channel valid (cfg write clears first).
    always_comb begin
        w_cfg_ok       = cfg_wr & ({1'b0, cfg_ch} < NUM_CH_L);
        w_cfg_dly      = clamp_delay(cfg_delay);
        w_cfg_hit      = {NUM_CH{1'b0}};
        w_fill_ok      = {NUM_CH{1'b0}};
        w_fill_short   = {NUM_CH{1'b0}};
        w_ch_valid_nxt = {NUM_CH{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            w_cfg_hit[c]    = w_cfg_ok & (cfg_ch == CH_W'(c));
            // Fill is compared before this sample's increment.
            w_fill_ok[c]    = (r_fill[c] >= r_delay[c]);
            w_fill_short[c] = ~w_fill_ok[c];
            if (w_cfg_hit[c]) begin
                w_ch_valid_nxt[c] = 1'b0;
            end else if (in_valid) begin
                w_ch_valid_nxt[c] = w_fill_ok[c];
            end else begin
                w_ch_valid_nxt[c] = r_ch_valid[c];
            end
        end
    end

    // Per-channel read mux: zero delay bypasses the buffer entirely.
    always_comb begin
        w_rd_data = {BUS_W{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_delay[c] == DLY_ZERO_L) begin
                w_rd_data[c*ADC_WIDTH +: ADC_WIDTH] = data_in[c*ADC_WIDTH +: ADC_WIDTH];
            end else begin
                w_rd_data[c*ADC_WIDTH +: ADC_WIDTH] = r_mem[c][tap_addr(r_wr_ptr, r_delay[c])];
            end
        end
    end

    // ---------------------------------------------------------------- seq
    // Sample buffers: plain storage, contents are qualified by the fill logic.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_mem[c][r_wr_ptr] <= data_in[c*ADC_WIDTH +: ADC_WIDTH];
            end
        end
    end

    // Shared write pointer, output data and the alignment pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_data_out <= {BUS_W{1'b0}};
            r_aligned  <= 1'b0;
        end else begin
            if (in_valid) begin
                // Power-of-two depth: natural wrap gives a bubble-free modulo.
                r_wr_ptr   <= r_wr_ptr + PTR_ONE_L;
                r_data_out <= w_rd_data;
                r_aligned  <= &w_ch_valid_nxt;
            end else begin
                r_wr_ptr   <= r_wr_ptr;
                r_data_out <= r_data_out;
                r_aligned  <= 1'b0;
            end
        end
    end

    // Per-channel delay, fill counter and valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_delay[c] <= DLY_ZERO_L;
                r_fill[c]  <= DLY_ZERO_L;
            end
            r_ch_valid <= {NUM_CH{1'b0}};
        end else begin
            r_ch_valid <= w_ch_valid_nxt;
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_cfg_hit[c]) begin
                    // A sample arriving on the same edge is not counted.
                    r_delay[c] <= w_cfg_dly;
                    r_fill[c]  <= DLY_ZERO_L;
                end else if (in_valid && (r_fill[c] != MAX_DLY_L)) begin
                    r_delay[c] <= r_delay[c];
                    r_fill[c]  <= r_fill[c] + DLY_ONE_L;
                end else begin
                    r_delay[c] <= r_delay[c];
                    r_fill[c]  <= r_fill[c];
                end
            end
        end
    end

    // Busy reflects the fill state sampled at each clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= |w_fill_short;
        end
    end

`ifdef WAVELET_ALIGN_MISALIGN_CNT_EN
    logic [15:0] r_misalign_cnt;

    // Saturating count of samples on which only part of the set is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign_cnt <= 16'h0000;
        end else if (w_cfg_ok) begin
            r_misalign_cnt <= 16'h0000;
        end else if (in_valid && (w_ch_valid_nxt != {NUM_CH{1'b0}}) &&
                     !(&w_ch_valid_nxt) && (r_misalign_cnt != 16'hFFFF)) begin
            r_misalign_cnt <= r_misalign_cnt + 16'h0001;
        end else begin
            r_misalign_cnt <= r_misalign_cnt;
        end
    end

    assign misalign_cnt = r_misalign_cnt;
`endif

    assign data_out      = r_data_out;
    assign ch_valid      = r_ch_valid;
    assign aligned_valid = r_aligned;
    assign busy          = r_busy;

endmodule

// File: tb/tb_wavelet_delay_aligner.sv
// -----------------------------------------------------------------------------
// Testbench for wavelet_delay_aligner. A table of directed vectors covers the
// reset/zero-delay behaviour, hand-written sequences cover reconfiguration and
// reset corners, and a randomized phase is checked against a sample-history
// reference model. A second small instance (NUM_CH = 3) covers an out-of-range
// channel select.
// -----------------------------------------------------------------------------
module tb_wavelet_delay_aligner;

    localparam int W  = 14;
    localparam int N  = 4;
    localparam int MD = 16;
    localparam int DW = 5;
    localparam int CW = 2;
    localparam int BW = N * W;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic [BW-1:0] data_in   = '0;
    logic          cfg_wr    = 1'b0;
    logic [CW-1:0] cfg_ch    = '0;
    logic [DW-1:0] cfg_delay = '0;
    logic [BW-1:0] data_out;
    logic [N-1:0]  ch_valid;
    logic          aligned_valid;
    logic          busy;

    logic          d3_cfg_wr = 1'b0;
    logic [1:0]    d3_cfg_ch = 2'd0;
    logic [3*W-1:0] d3_data_out;
    logic [2:0]    d3_ch_valid;
    logic          d3_aligned;
    logic          d3_busy;

`ifdef WAVELET_ALIGN_MISALIGN_CNT_EN
    logic [15:0]   misalign_cnt;
    logic [15:0]   d3_misalign_cnt;
`endif

    wavelet_delay_aligner #(.ADC_WIDTH(W), .NUM_CH(N), .MAX_DELAY(MD)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in),
        .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay),
        .data_out(data_out), .ch_valid(ch_valid),
        .aligned_valid(aligned_valid), .busy(busy)
`ifdef WAVELET_ALIGN_MISALIGN_CNT_EN
        , .misalign_cnt(misalign_cnt)
`endif
    );

    wavelet_delay_aligner #(.ADC_WIDTH(W), .NUM_CH(3), .MAX_DELAY(MD)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in[3*W-1:0]),
        .cfg_wr(d3_cfg_wr), .cfg_ch(d3_cfg_ch), .cfg_delay(cfg_delay),
        .data_out(d3_data_out), .ch_valid(d3_ch_valid),
        .aligned_valid(d3_aligned), .busy(d3_busy)
`ifdef WAVELET_ALIGN_MISALIGN_CNT_EN
        , .misalign_cnt(d3_misalign_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------- reference model
    int            m_delay [N];
    int            m_fill  [N];
    logic [N-1:0]  m_cv;
    logic [N-1:0]  m_dk;
    logic [BW-1:0] m_dout;
    logic          m_al;
    logic          m_busy;
    int            m_cnt;
    logic [BW-1:0] hist [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] mk(input int base);
        logic [BW-1:0] r;
        for (int c = 0; c < N; c++) r[c*W +: W] = W'(base + c * 1000);
        return r;
    endfunction

    function automatic logic [63:0] lane(input logic [BW-1:0] v, input int c);
        return 64'(v[c*W +: W]);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_delay[c] = 0;
            m_fill[c]  = 0;
        end
        m_cv = '0; m_dk = '1; m_dout = '0; m_al = 1'b0; m_busy = 1'b0; m_cnt = 0;
        hist.delete();
    endtask

    // One clock edge of the specified behaviour, using the sample history.
    task automatic model_edge(input logic v, input logic [BW-1:0] din,
                              input logic wr, input int ch, input int dly);
        logic [N-1:0]  nxt;
        logic [BW-1:0] old;
        m_busy = 1'b0;
        for (int c = 0; c < N; c++) if (m_fill[c] < m_delay[c]) m_busy = 1'b1;
        nxt = m_cv;
        if (v) begin
            for (int c = 0; c < N; c++) begin
                nxt[c] = (m_fill[c] >= m_delay[c]);
                if (m_delay[c] == 0) begin
                    m_dout[c*W +: W] = din[c*W +: W];
                    m_dk[c] = 1'b1;
                end else if (hist.size() >= m_delay[c]) begin
                    old = hist[hist.size() - m_delay[c]];
                    m_dout[c*W +: W] = old[c*W +: W];
                    m_dk[c] = 1'b1;
                end else begin
                    m_dk[c] = 1'b0;
                end
                if (m_fill[c] < MD) m_fill[c]++;
            end
            hist.push_back(din);
            if (hist.size() > 40) void'(hist.pop_front());
        end
        if (wr && ch < N) begin
            nxt[ch] = 1'b0;
            m_delay[ch] = (dly > MD) ? MD : dly;
            m_fill[ch] = 0;
            m_cnt = 0;
        end else if (v && nxt != '0 && nxt != '1 && m_cnt < 65535) begin
            m_cnt++;
        end
        m_al = v && (&nxt);
        m_cv = nxt;
    endtask

    task automatic compare_all();
        chk("ch_valid", 64'(ch_valid), 64'(m_cv));
        chk("aligned_valid", 64'(aligned_valid), 64'(m_al));
        chk("busy", 64'(busy), 64'(m_busy));
        for (int c = 0; c < N; c++) begin
            if (m_cv[c] && m_dk[c]) chk($sformatf("data_ch%0d", c), lane(data_out, c), lane(m_dout, c));
        end
`ifdef WAVELET_ALIGN_MISALIGN_CNT_EN
        chk("misalign_cnt", 64'(misalign_cnt), 64'(m_cnt));
`endif
    endtask

    // Apply one cycle of inputs, advance the model, compare after the edge.
    task automatic cyc(input logic v, input logic [BW-1:0] din,
                       input logic wr, input int ch, input int dly);
        in_valid  = v;
        data_in   = din;
        cfg_wr    = wr;
        cfg_ch    = CW'(ch);
        cfg_delay = DW'(dly);
        @(posedge clk);
        model_edge(v, din, wr, ch, dly);
        #1;
        compare_all();
        in_valid = 1'b0;
        cfg_wr   = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        cfg_wr   = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk("rst_data_out", 64'(data_out), 64'd0);
        chk("rst_ch_valid", 64'(ch_valid), 64'd0);
        chk("rst_aligned", 64'(aligned_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
    endtask

    // ------------------------------------------------------- directed table
    typedef struct {
        logic         v;
        int           base;
        logic [N-1:0] ecv;
        logic         eal;
        int           edout;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int first_al;
        int first_bz;
        logic [63:0] rnd;

        // Zero delays: output equals the input of the same valid event, one clk later.
        tbl[0] = '{1'b1, 1, 4'hF, 1'b1, 1};
        tbl[1] = '{1'b1, 2, 4'hF, 1'b1, 2};
        tbl[2] = '{1'b0, 3, 4'hF, 1'b0, 2};
        tbl[3] = '{1'b1, 4, 4'hF, 1'b1, 4};
        tbl[4] = '{1'b1, 5, 4'hF, 1'b1, 5};
        tbl[5] = '{1'b0, 6, 4'hF, 1'b0, 5};

        model_reset();
        do_reset();

        for (int i = 0; i < 6; i++) begin
            cyc(tbl[i].v, mk(tbl[i].base), 1'b0, 0, 0);
            chk($sformatf("tbl%0d_ch_valid", i), 64'(ch_valid), 64'(tbl[i].ecv));
            chk($sformatf("tbl%0d_aligned", i), 64'(aligned_valid), 64'(tbl[i].eal));
            chk($sformatf("tbl%0d_data", i), 64'(data_out), 64'(mk(tbl[i].edout)));
        end

        // Delays {0,2,3,15}, then a ramp from 0.
        cyc(1'b0, mk(0), 1'b1, 0, 0);
        cyc(1'b0, mk(0), 1'b1, 1, 2);
        cyc(1'b0, mk(0), 1'b1, 2, 3);
        cyc(1'b0, mk(0), 1'b1, 3, 15);
        first_al = 0;
        first_bz = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1, mk(k), 1'b0, 0, 0);
            if (aligned_valid && first_al == 0) first_al = k + 1;
            if (!busy && first_bz == 0) first_bz = k + 1;
        end
        chk("first_aligned_index", 64'(first_al), 64'd16);
        chk("busy_clear_index", 64'(first_bz), 64'd16);
        chk("ch3_ramp_k_minus_15", lane(data_out, 3), 64'(19 - 15 + 3000));

        // Gapped input with delay 2: idle cycles do not advance anything.
        cyc(1'b0, mk(0), 1'b1, 3, 2);
        for (int j = 0; j < 16; j++) cyc((j % 2) == 0, mk(50 + j), 1'b0, 0, 0);

        // Oversized delay clamps to MAX_DELAY.
        cyc(1'b0, mk(0), 1'b1, 1, 20);
        for (int k = 100; k < 120; k++) cyc(1'b1, mk(k), 1'b0, 0, 0);
        chk("ch1_clamped_tap", lane(data_out, 1), 64'(103 + 1000));
        chk("ch1_clamped_valid", 64'(ch_valid[1]), 64'd1);

        // Out-of-range channel on the 3-channel instance is ignored.
        d3_cfg_wr = 1'b1;
        d3_cfg_ch = 2'd3;
        cyc(1'b1, mk(120), 1'b0, 0, 5);
        d3_cfg_wr = 1'b0;
        chk("d3_ignored_ch_valid", 64'(d3_ch_valid), 64'h7);
        cyc(1'b1, mk(121), 1'b0, 0, 0);
        chk("d3_ignored_busy", 64'(d3_busy), 64'd0);
        chk("d3_ignored_ch_valid2", 64'(d3_ch_valid), 64'h7);

        // Reconfigure ch2 3 -> 5 together with a sample: that sample uses delay 3.
        cyc(1'b1, mk(200), 1'b1, 2, 5);
        chk("reconf_old_delay_data", lane(data_out, 2), 64'(119 + 2000));
        chk("reconf_valid_drop", 64'(ch_valid), 64'hB);
        for (int j = 1; j <= 6; j++) begin
            cyc(1'b1, mk(200 + j), 1'b0, 0, 0);
            if (j == 5) chk("reconf_still_filling", 64'(ch_valid), 64'hB);
            if (j == 6) chk("reconf_refilled", 64'(ch_valid), 64'hF);
        end

        // Asynchronous reset between edges clears outputs at once.
        cyc(1'b1, mk(300), 1'b0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_data", 64'(data_out), 64'd0);
        chk("async_rst_ch_valid", 64'(ch_valid), 64'd0);
        chk("async_rst_aligned", 64'(aligned_valid), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
`ifdef WAVELET_ALIGN_MISALIGN_CNT_EN
        chk("async_rst_misalign", 64'(misalign_cnt), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 4; k++) cyc(1'b1, mk(400 + k), 1'b0, 0, 0);

        // Randomized traffic and reconfiguration.
        for (int i = 0; i < 400; i++) begin
            rnd = {$urandom(), $urandom()};
            cyc(($urandom % 4) != 0, rnd[BW-1:0], ($urandom % 12) == 0,
                int'($urandom % 4), int'($urandom % 21));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
